// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with a two-state refill engine.
// A hit returns the word in the same cycle. A miss stalls the pipeline while the
// whole line is fetched from backing memory, one word per beat in address order.
module icache_dm #(
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 64,
    parameter logic [31:0] RESET_PC   = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_valid,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LINE_W = 30 - OFF_W;          // line-number bits (index + tag)
    localparam int TAG_W  = LINE_W - IDX_W;

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [NUM_LINES-1:0]      r_valid;
    logic [TAG_W-1:0]          r_tag  [NUM_LINES];
    logic [31:0]               r_data [NUM_LINES*LINE_WORDS];
    logic [LINE_W-1:0]         r_line;           // latched line number of the refill
    logic [OFF_W-1:0]          r_beat;
    logic                      r_flush_pend;
    logic [31:0]               r_hit_count;
    logic [31:0]               r_miss_count;

    logic [OFF_W-1:0]          w_off;
    logic [IDX_W-1:0]          w_idx;
    logic [TAG_W-1:0]          w_tag;
    logic [IDX_W-1:0]          w_fill_idx;
    logic                      w_hit;
    logic                      w_miss;
    logic                      w_last;
    logic                      w_unused;

    assign w_off      = cpu_addr[OFF_W+1:2];
    assign w_idx      = cpu_addr[OFF_W+2 +: IDX_W];
    assign w_tag      = cpu_addr[31 -: TAG_W];
    assign w_fill_idx = r_line[IDX_W-1:0];
    assign w_last     = (r_beat == OFF_W'(LINE_WORDS - 1));
    assign w_hit      = (r_state == S_IDLE) && cpu_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss     = (r_state == S_IDLE) && cpu_req && !w_hit;
    // Byte-lane bits of the fetch address carry no information for word fetches.
    assign w_unused   = &{1'b0, cpu_addr[1:0]};

    // State register; reset abandons any refill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state: enter refill on a miss, leave after the last beat is accepted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_miss)              w_state_next = S_REFILL;
            S_REFILL: if (mem_ready && w_last) w_state_next = S_IDLE;
            default:                           w_state_next = S_IDLE;
        endcase
    end

    // Outputs: hit data is combinational; refill issues one word address per beat.
    always_comb begin
        cpu_rdata  = r_data[{w_idx, w_off}];
        cpu_valid  = w_hit;
        stall      = (r_state == S_REFILL) || w_miss;
        mem_req    = (r_state == S_REFILL);
        mem_addr   = {r_line, r_beat, 2'b00};
        hit_count  = r_hit_count;
        miss_count = r_miss_count;
    end

    // Control state: valid bits, refill bookkeeping, saturating counters.
    // A flush seen during refill (including on the last beat) keeps the
    // incoming line invalid and wipes every line once the refill ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= '0;
            r_line       <= RESET_PC[31:OFF_W+2];
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit && (r_hit_count != 32'hFFFF_FFFF))
                        r_hit_count <= r_hit_count + 32'd1;
                    if (w_miss) begin
                        r_line <= cpu_addr[31:OFF_W+2];
                        r_beat <= '0;
                        if (r_miss_count != 32'hFFFF_FFFF)
                            r_miss_count <= r_miss_count + 32'd1;
                    end
                    if (flush)
                        r_valid <= '0;
                end
                S_REFILL: begin
                    if (flush)
                        r_flush_pend <= 1'b1;
                    if (mem_ready) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_flush_pend <= 1'b0;
                            if (r_flush_pend || flush) r_valid <= '0;
                            else                       r_valid[w_fill_idx] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage: each accepted beat writes one word, the tag lands with the last beat.
    always_ff @(posedge clk) begin
        if ((r_state == S_REFILL) && mem_ready) begin
            r_data[{w_fill_idx, r_beat}] <= mem_rdata;
            if (w_last)
                r_tag[w_fill_idx] <= r_line[IDX_W +: TAG_W];
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hits, conflict eviction, memory
// back-pressure, flush during refill and in idle, and reset mid-refill.
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_valid;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Backing memory: line 0 of the 4 KiB window holds 0x11,0x22,0x33,0x44;
    // other lines put their line number (addr[11:4]) in the top byte.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = {30'b0, a[3:2]} + 32'd1;
        return {a[11:4], 24'h0} ^ (32'h11 * k);
    endfunction
    assign mem_rdata = mem_word(mem_addr);

    icache_dm dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .cpu_valid  (cpu_valid),
        .stall      (stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s got=%08h", tag, got);
        end else begin
            $display("FAIL %-14s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full miss with mem_ready high: stall now, four ordered beats, hit afterwards.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] base;
        base     = addr & ~32'hF;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        #1;
        chk("miss_stall", {31'b0, stall}, 32'd1);
        chk("miss_nvalid", {31'b0, cpu_valid}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            step();
            chk("fill_req", {31'b0, mem_req}, 32'd1);
            chk("fill_addr", mem_addr, base + 32'(4 * b));
        end
        step();
        chk("retry_valid", {31'b0, cpu_valid}, 32'd1);
        chk("retry_data", cpu_rdata, exp);
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = 32'h0;
        flush     = 1'b0;
        mem_ready = 1'b1;
        step();
        step();
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_miss", miss_count, 32'd0);
        chk("rst_memreq", {31'b0, mem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        step();

        // Cold fetch of the reset vector; data visible in cycle 6.
        do_miss(32'hBFC00000, 32'h00000011);
        chk("cold_miss", miss_count, 32'd1);

        // Neighbouring words hit in the same cycle.
        step();
        cpu_addr = 32'hBFC00004;
        #1;
        chk("hit4_valid", {31'b0, cpu_valid}, 32'd1);
        chk("hit4_data", cpu_rdata, 32'h00000022);
        chk("hit4_stall", {31'b0, stall}, 32'd0);
        step();
        cpu_addr = 32'hBFC00008;
        #1;
        chk("hit8_data", cpu_rdata, 32'h00000033);
        step();
        cpu_req = 1'b0;
        #1;
        chk("hit_count3", hit_count, 32'd3);
        chk("idle_stall", {31'b0, stall}, 32'd0);
        step();
        chk("idle_nochg", hit_count, 32'd3);

        // Conflict on index 0: each address evicts the other.
        do_miss(32'hBFC00400, 32'h40000011);
        step();
        do_miss(32'hBFC00000, 32'h00000011);
        step();
        cpu_req = 1'b0;
        #1;
        chk("conf_miss", miss_count, 32'd3);
        chk("conf_hits", hit_count, 32'd5);

        // Memory stalls three cycles on beat 1.
        cpu_req  = 1'b1;
        cpu_addr = 32'hBFC00014;
        step();
        chk("bp_beat0", mem_addr, 32'hBFC00010);
        step();
        mem_ready = 1'b0;
        #1;
        chk("bp_beat1", mem_addr, 32'hBFC00014);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_addr", mem_addr, 32'hBFC00014);
            chk("bp_hold_stall", {31'b0, stall}, 32'd1);
        end
        mem_ready = 1'b1;
        cpu_addr  = 32'hBFC00400;   // must not redirect the refill
        step();
        chk("bp_beat2", mem_addr, 32'hBFC00018);
        step();
        chk("bp_beat3", mem_addr, 32'hBFC0001C);
        cpu_addr = 32'hBFC00014;
        step();
        chk("bp_valid", {31'b0, cpu_valid}, 32'd1);
        chk("bp_data", cpu_rdata, 32'h01000022);
        step();
        chk("bp_counts", miss_count, 32'd4);

        // Flush during beat 2: the line stays invalid and is fetched again.
        cpu_addr = 32'hBFC00020;
        step();
        step();
        step();
        chk("fl_beat2", mem_addr, 32'hBFC00028);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("fl_retry_miss", {31'b0, cpu_valid}, 32'd0);
        chk("fl_retry_stall", {31'b0, stall}, 32'd1);
        step();
        chk("fl_new_req", {31'b0, mem_req}, 32'd1);
        chk("fl_new_addr", mem_addr, 32'hBFC00020);
        chk("fl_miss6", miss_count, 32'd6);
        step();
        step();
        step();
        step();
        chk("fl_hit_data", cpu_rdata, 32'h02000011);

        // Flush in idle: this cycle still hits, the next one misses.
        flush = 1'b1;
        #1;
        chk("fli_pre_hit", {31'b0, cpu_valid}, 32'd1);
        step();
        flush = 1'b0;
        #1;
        chk("fli_post_miss", {31'b0, stall}, 32'd1);
        chk("fli_hits", hit_count, 32'd7);

        // Reset during beat 2 aborts the refill immediately.
        step();
        step();
        step();
        chk("rr_beat2", mem_addr, 32'hBFC00028);
        rst = 1'b1;
        #1;
        chk("rr_memreq", {31'b0, mem_req}, 32'd0);
        chk("rr_hits", hit_count, 32'd0);
        chk("rr_miss", miss_count, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rr_refetch", {31'b0, stall}, 32'd1);
        chk("rr_nvalid", {31'b0, cpu_valid}, 32'd0);
        step();
        chk("rr_req", {31'b0, mem_req}, 32'd1);
        chk("rr_addr", mem_addr, 32'hBFC00020);
        chk("rr_miss1", miss_count, 32'd1);

        cpu_req = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
